// File: rtl/tennis_pkg.sv
// Shared types for the tennis scoreboard: point codes, point-FSM and match-FSM states.
// Optional feature macro (used by tennis_game_fsm): TENNIS_NO_AD_SCORING_EN.
package tennis_pkg;

    typedef enum logic [2:0] {
        LOVE = 3'd0,
        P15  = 3'd1,
        P30  = 3'd2,
        P40  = 3'd3,
        AD   = 3'd4
    } pt_code_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DEUCE  = 2'd1,
        ADV_L  = 2'd2,
        ADV_R  = 2'd3
    } pt_state_t;

    typedef enum logic {
        PLAY       = 1'b0,
        MATCH_OVER = 1'b1
    } match_state_t;

    // Saturates at 40; reaching advantage is handled by the point FSM, not by counting.
    function automatic pt_code_t pt_inc(input pt_code_t p);
        pt_code_t r;
        case (p)
            LOVE:    r = P15;
            P15:     r = P30;
            default: r = P40;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tennis_game_fsm.sv
// Per-game point FSM: tracks both point codes and flags the point that wins the game.
// Macro TENNIS_NO_AD_SCORING_EN selects sudden-death scoring at 40-40 (no deuce/advantage).
//
// state  | meaning
// NORMAL | ordinary scoring, neither side past 40 together
// DEUCE  | 40-40 with advantage scoring
// ADV_L  | left holds advantage (code 4)
// ADV_R  | right holds advantage (code 4)
module tennis_game_fsm
    import tennis_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     clear,
    input  logic     pointLeft,
    input  logic     pointRight,
    output pt_code_t ptsLeft,
    output pt_code_t ptsRight,
    output logic     gameWonLeft,
    output logic     gameWonRight,
    output logic     winLeftNext,
    output logic     winRightNext
);

`ifdef TENNIS_NO_AD_SCORING_EN
    localparam bit AD_SCORING = 1'b0;
`else
    localparam bit AD_SCORING = 1'b1;
`endif

    pt_state_t state_q, state_d;
    pt_code_t  pl_q, pl_d, pr_q, pr_d;
    logic      won_l_q, won_r_q;
    logic      win_l, win_r;

    always_comb begin
        state_d = state_q;
        pl_d    = pl_q;
        pr_d    = pr_q;
        win_l   = 1'b0;
        win_r   = 1'b0;
        if (clear) begin
            state_d = NORMAL;
            pl_d    = LOVE;
            pr_d    = LOVE;
        end else if (pointLeft ^ pointRight) begin
            case (state_q)
                NORMAL: begin
                    // With advantage scoring 40-40 lives in DEUCE, so 40 here always wins.
                    if (pointLeft) begin
                        if (pl_q == P40) begin
                            win_l = 1'b1;
                        end else begin
                            pl_d = pt_inc(pl_q);
                            if (AD_SCORING && pl_q == P30 && pr_q == P40)
                                state_d = DEUCE;
                        end
                    end else begin
                        if (pr_q == P40) begin
                            win_r = 1'b1;
                        end else begin
                            pr_d = pt_inc(pr_q);
                            if (AD_SCORING && pr_q == P30 && pl_q == P40)
                                state_d = DEUCE;
                        end
                    end
                end
                DEUCE: begin
                    if (pointLeft) begin
                        state_d = ADV_L;
                        pl_d    = AD;
                    end else begin
                        state_d = ADV_R;
                        pr_d    = AD;
                    end
                end
                ADV_L: begin
                    if (pointLeft) begin
                        win_l = 1'b1;
                    end else begin
                        state_d = DEUCE;
                        pl_d    = P40;
                        pr_d    = P40;
                    end
                end
                ADV_R: begin
                    if (pointRight) begin
                        win_r = 1'b1;
                    end else begin
                        state_d = DEUCE;
                        pl_d    = P40;
                        pr_d    = P40;
                    end
                end
                default: state_d = NORMAL;
            endcase
            if (win_l || win_r) begin
                state_d = NORMAL;
                pl_d    = LOVE;
                pr_d    = LOVE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= NORMAL;
            pl_q    <= LOVE;
            pr_q    <= LOVE;
            won_l_q <= 1'b0;
            won_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pl_q    <= pl_d;
            pr_q    <= pr_d;
            won_l_q <= win_l;
            won_r_q <= win_r;
        end
    end

    assign ptsLeft      = pl_q;
    assign ptsRight     = pr_q;
    assign gameWonLeft  = won_l_q;
    assign gameWonRight = won_r_q;
    assign winLeftNext  = win_l;
    assign winRightNext = win_r;

    a_no_ad_states: assert property (@(posedge clk) disable iff (reset)
        !AD_SCORING |-> (state_q == NORMAL && pl_q != AD && pr_q != AD));

endmodule

// File: rtl/tennis_scoreboard.sv
// Tennis match scoreboard: games counters, match FSM and server tracking around tennis_game_fsm.
// Macro TENNIS_NO_AD_SCORING_EN (handled in tennis_game_fsm) selects no-advantage scoring.
module tennis_scoreboard
    import tennis_pkg::*;
#(
    parameter int GAMES_TO_WIN = 6
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       pointLeft,
    input  logic       pointRight,
    input  logic       newMatch,
    output logic [2:0] ptsLeft,
    output logic [2:0] ptsRight,
    output logic [3:0] gamesLeft,
    output logic [3:0] gamesRight,
    output logic       serveLeft,
    output logic       gameWon,
    output logic       matchOver,
    output logic       winnerLeft
);

    localparam logic [3:0] GAMES_MAX = 4'(GAMES_TO_WIN);

    match_state_t state_q, state_d;
    logic [3:0]   gl_q, gl_d, gr_q, gr_d;
    logic         serve_q, serve_d;
    logic         first_q, first_d;
    logic         winl_q, winl_d;

    logic         point_en, pl_g, pr_g;
    pt_code_t     pts_l, pts_r;
    logic         won_l, won_r, win_l, win_r;

    // Points only reach the game FSM during play and when no new match is requested.
    assign point_en = (state_q == PLAY) && !newMatch;
    assign pl_g     = pointLeft  && point_en;
    assign pr_g     = pointRight && point_en;

    tennis_game_fsm u_game (
        .clk          (CLK100MHZ),
        .reset        (reset),
        .clear        (newMatch),
        .pointLeft    (pl_g),
        .pointRight   (pr_g),
        .ptsLeft      (pts_l),
        .ptsRight     (pts_r),
        .gameWonLeft  (won_l),
        .gameWonRight (won_r),
        .winLeftNext  (win_l),
        .winRightNext (win_r)
    );

    always_comb begin
        state_d = state_q;
        gl_d    = gl_q;
        gr_d    = gr_q;
        serve_d = serve_q;
        first_d = first_q;
        winl_d  = winl_q;
        if (newMatch) begin
            // The opening server alternates from match to match.
            state_d = PLAY;
            gl_d    = 4'd0;
            gr_d    = 4'd0;
            first_d = ~first_q;
            serve_d = ~first_q;
            winl_d  = 1'b0;
        end else if (state_q == PLAY && (win_l || win_r)) begin
            serve_d = ~serve_q;
            if (win_l) begin
                if (gl_q < GAMES_MAX)
                    gl_d = gl_q + 4'd1;
                if (gl_q == GAMES_MAX - 4'd1) begin
                    state_d = MATCH_OVER;
                    winl_d  = 1'b1;
                end
            end else begin
                if (gr_q < GAMES_MAX)
                    gr_d = gr_q + 4'd1;
                if (gr_q == GAMES_MAX - 4'd1) begin
                    state_d = MATCH_OVER;
                    winl_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q <= PLAY;
            gl_q    <= 4'd0;
            gr_q    <= 4'd0;
            serve_q <= 1'b1;
            first_q <= 1'b1;
            winl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gl_q    <= gl_d;
            gr_q    <= gr_d;
            serve_q <= serve_d;
            first_q <= first_d;
            winl_q  <= winl_d;
        end
    end

    assign ptsLeft    = pts_l;
    assign ptsRight   = pts_r;
    assign gamesLeft  = gl_q;
    assign gamesRight = gr_q;
    assign serveLeft  = serve_q;
    assign gameWon    = won_l | won_r;
    assign matchOver  = (state_q == MATCH_OVER);
    assign winnerLeft = winl_q;

    a_games_bound: assert property (@(posedge CLK100MHZ) disable iff (reset)
        (gl_q <= GAMES_MAX) && (gr_q <= GAMES_MAX));

endmodule

// File: doc/tennis_scoreboard.md
TENNIS_SCOREBOARD -- requirements
Module: tennis_scoreboard

Interface
REQ-001 Parameter GAMES_TO_WIN, default 6, is the number of games needed to win the match; legal range 1..15.
REQ-002 CLK100MHZ  input  1  the single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pointLeft  input  1  one-cycle pulse: the left player won the point (the ball left the court past the right racquet).
REQ-005 pointRight  input  1  one-cycle pulse: the right player won the point.
REQ-006 newMatch  input  1  one-cycle pulse: clear all scores and start a new match.
REQ-007 ptsLeft, ptsRight  output  3 each  point code: 0=love, 1=15, 2=30, 3=40, 4=AD.
REQ-008 gamesLeft, gamesRight  output  4 each  games won in the current match.
REQ-009 serveLeft  output  1  1 = the left player serves the current game.
REQ-010 gameWon  output  1  one-cycle pulse when a game completes.
REQ-011 matchOver  output  1  level; high once a player reaches GAMES_TO_WIN games.
REQ-012 winnerLeft  output  1  valid while matchOver is high; 1 = the left player won the match.

Function
REQ-013 All outputs SHALL be registered, and every update SHALL be visible on the cycle after the triggering input pulse.
REQ-014 Main FSM states: PLAY and MATCH_OVER; per-game point FSM states: NORMAL, DEUCE, ADV_L, ADV_R.
REQ-015 NORMAL: a point to a side below 40 SHALL advance that side's code by 1 (0->1->2->3).
REQ-016 NORMAL: a point to a side at 40 while the opponent is below 40 SHALL win the game.
REQ-017 A point that makes the score 40-40 SHALL move the point FSM to DEUCE, with both codes at 3.
REQ-018 DEUCE: a point to a side SHALL move to ADV of that side, setting that side's code to 4.
REQ-019 ADV_x: a point to x SHALL win the game for x; a point to the opponent SHALL return to DEUCE, restoring both codes to 3.
REQ-020 On a game win, in the same update: winner's games +1, both point codes reset to 0, point FSM returns to NORMAL, serveLeft toggles, gameWon pulses for exactly one cycle.
REQ-021 When the winner's incremented game count equals GAMES_TO_WIN, the main FSM SHALL enter MATCH_OVER in that same update.
REQ-022 Entering MATCH_OVER SHALL set matchOver=1 and latch winnerLeft; gameWon still pulses for that final game.
REQ-023 In MATCH_OVER, pointLeft and pointRight SHALL be ignored, and all scores SHALL hold.
REQ-024 If pointLeft and pointRight are asserted in the same cycle, both SHALL be ignored and no state SHALL change.
REQ-025 newMatch SHALL have priority over point pulses in the same cycle and SHALL produce the reset values of REQ-027, except that serveLeft toggles relative to the first server of the previous match.
REQ-026 Games counters SHALL never exceed GAMES_TO_WIN, and no arithmetic SHALL wrap.

Reset
REQ-027 On reset, the block SHALL go to PLAY/NORMAL with: pts 0/0, games 0/0, serveLeft=1, gameWon=0, matchOver=0, winnerLeft=0.
REQ-028 Reset asserted mid-game or mid-pulse SHALL abandon the pulse, with no partial update.

Configuration
REQ-029 Macro TENNIS_NO_AD_SCORING_EN defined: at 40-40 the next point SHALL win the game; the DEUCE, ADV_L and ADV_R states and code 4 SHALL never occur.
REQ-030 Macro TENNIS_NO_AD_SCORING_EN undefined: deuce/advantage behaviour SHALL follow REQ-017..REQ-019.

Structure
REQ-031 Package tennis_pkg SHALL hold the point-code typedef (3-bit enum LOVE, P15, P30, P40, AD), the point FSM state enum, and the main FSM state enum.
REQ-032 The per-game point FSM SHALL be a sub-module, tennis_game_fsm, which outputs both point codes and a one-cycle gameWonLeft/gameWonRight pulse; the games counters, match FSM and server logic stay in tennis_scoreboard.

Verification
REQ-033 Reset, then four pointLeft pulses -> ptsLeft 1,2,3; on the fourth pulse gameWon=1 for one cycle, gamesLeft=1, pts 0/0, serveLeft=0.
REQ-034 3 L + 3 R points, then R, L, L, L -> sequence DEUCE (3/3), ADV_R (3/4), DEUCE, ADV_L (4/3), game to left, gamesLeft=1.
REQ-035 Same stimulus with TENNIS_NO_AD_SCORING_EN -> the seventh point (R) wins the game for right; gamesRight=1.
REQ-036 GAMES_TO_WIN=2, right wins two games -> matchOver=1, winnerLeft=0; further point pulses leave all outputs unchanged.
REQ-037 pointLeft and pointRight asserted in the same cycle at 30-15 -> no change; newMatch coinciding with pointLeft -> full clear, and no point is scored.
REQ-038 Asynchronous reset pulsed between clock edges at ADV_L -> outputs take reset values immediately; the next clock edge shows pts 0/0.
